alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU that is the next generation of the team's 32-bit combinational ALU.
- Keeps the same 3-bit opcode map and the c/n/z/v flags.
- Adds operand width WIDTH, valid/ready handshakes on both sides with full backpressure, and a stored carry register for multi-word add/subtract chains.
- Sits between the register-file read stage and the writeback buffer.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4 to 64).
- CNT_W, 16, width of the optional overflow event counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  000 NOT A, 001 NOT B, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ADD, 111 SUB
- use_c  in  1  ADD/SUB only: carry-in taken from the stored carry register
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH  ALU result
- c, n, z, v  out  1 each  carry, negative, zero, overflow flags of result
- ovf_cnt  out  CNT_W  overflow event count (present only with ALU_OVF_CNT_EN)
- cnt_clr  in  1  clear ovf_cnt (present only with ALU_OVF_CNT_EN)

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - s1_valid, s2_valid, carry register and ovf_cnt go to 0.
  - result, c, n, z, v go to 0; out_valid=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight beats with no output.
- Pipeline:
  - Stage 1 registers a, b, op and use_c on an accepted beat (in_valid & in_ready).
  - The ALU function and flags are computed combinationally from stage 1.
  - Stage 2 registers the computed values on the s1→s2 transfer.
- Latency: 2 cycles from input accept to out_valid when unstalled. Throughput: 1 beat/cycle.
- Handshake rules:
  - s2_adv = !s2_valid | out_ready.
  - s1 moves to s2 when s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv; it is combinational and never depends on in_valid.
  - out_valid = s2_valid.
  - result and flags hold stable while out_valid & !out_ready.
  - Beats are never dropped or duplicated, and order is preserved.
- Arithmetic:
  - ADD: {co, s} = a + b + ci.
  - SUB: {co, s} = a + ~b + ci.
  - ci: ADD uses use_c ? carry_reg : 0. SUB uses use_c ? carry_reg : 1.
  - ADD/SUB flags: c=co; v = carry into MSB XOR carry out of MSB.
- Logical ops: c=0, v=0.
- All ops: n=result[WIDTH-1]; z=(result==0).
- Carry register:
  - Loaded with co only on an s1→s2 transfer of an ADD/SUB beat.
  - Unchanged by logical ops.
  - Back-to-back chained beats see the carry of the immediately preceding ADD/SUB in issue order, with no bubble required.
- Simultaneous events:
  - Accepting a new beat while s1 advances is legal: s1 loads the new beat in the same cycle.
  - Output accept and s1→s2 transfer in the same cycle is legal.
- Full condition: s1 and s2 both valid and out_ready=0 → in_ready=0.

Optional Feature:
- Macro: ALU_OVF_CNT_EN.
- Defined:
  - ovf_cnt increments by 1 on each output handshake (out_valid & out_ready) carrying v=1.
  - The counter saturates at all-ones.
  - cnt_clr=1 sets it to 0 next cycle and has priority over an increment in the same cycle.
  - Reset clears it.
- Undefined: ovf_cnt and cnt_clr ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, out_ready=1: ADD a=0x7FFFFFFF b=1 → two cycles later result=0x80000000, n=1, v=1, c=0, z=0.
- WIDTH=32: SUB a=5 b=5 → result=0, z=1, c=1, v=0; then XOR a=0xFFFF0000 b=0x0000FFFF → result=0xFFFFFFFF, n=1, c=0, v=0.
- Multi-word chain, WIDTH=32, beats issued back-to-back:
  - ADD a=0xFFFFFFFF b=1 use_c=0 → result=0, c=1.
  - Next ADD a=0 b=0 use_c=1 → result=1, c=0.
- Backpressure: stream 4 ADD beats with out_ready=0 → in_ready drops after 2 accepts. Raise out_ready → 4 results in order, none lost or duplicated, result stable while stalled.
- Reset mid-stream: reset_n=0 for one cycle with both stages full → out_valid=0, flags 0, carry 0, in_ready=1 next cycle.
- ALU_OVF_CNT_EN defined: 3 overflowing ADDs accepted at the output → ovf_cnt=3. Assert cnt_clr in the same cycle as a 4th overflow handshake → ovf_cnt=0.

Source files
------------

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU sitting between register-file read and the writeback
// buffer. Uses the same 3-bit opcode map and c/n/z/v flags as the older
// combinational ALU, and adds a parametrised width, valid/ready handshakes
// with full backpressure on both sides, and a stored carry register for
// multi-word ADD/SUB chains.
//
// Parameters
//   WIDTH  operand/result width, 4..64
//   CNT_W  width of the optional overflow event counter
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (never depends on in_valid)
//   a, b       operands
//   op         000 NOT A, 001 NOT B, 010 AND, 011 OR,
//              100 XOR,   101 XNOR,  110 ADD, 111 SUB
//   use_c      ADD/SUB only: carry-in comes from the stored carry register
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   result     ALU result
//   c, n, z, v carry / negative / zero / overflow flags of result
//   ovf_cnt    overflow event counter      (only with ALU_OVF_CNT_EN)
//   cnt_clr    clear ovf_cnt               (only with ALU_OVF_CNT_EN)
//
// Configuration macro
//   ALU_OVF_CNT_EN  when defined, adds a saturating counter of output
//                   handshakes that carry v=1, plus its clear input.
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
`ifdef ALU_OVF_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_NOT_A = 3'b000,
    OP_NOT_B = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ADD   = 3'b110,
    OP_SUB   = 3'b111
  } op_e;

  // Stage 1: registered operands
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             s1_use_c_q, s1_use_c_d;

  // Stage 2: registered result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             v_q, v_d;

  // Stored carry for chained multi-word arithmetic
  logic             carry_q, carry_d;

  // Handshake control
  logic             s2_adv;
  logic             s1_xfer;
  logic             in_accept;

  // Combinational ALU outputs computed from stage 1
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic             carry_in;
  logic [WIDTH:0]   sum_full;
  logic             carry_into_msb;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  // Handshake: stage 2 can take new data when it is empty or being drained;
  // stage 1 can take new data when it is empty or moving into stage 2. This
  // keeps full throughput while letting backpressure ripple back by one stage.
  always_comb begin
    s2_adv    = !s2_valid_q || out_ready;
    s1_xfer   = s1_valid_q && s2_adv;
    in_ready  = !s1_valid_q || s2_adv;
    in_accept = in_valid && in_ready;
  end

  // ALU datapath. SUB is done as A + ~B + ci so ADD and SUB share one adder.
  // The carry into the MSB is recovered from the MSB sum bit and the MSB
  // operand bits, so overflow needs no second adder.
  always_comb begin
    is_arith       = (s1_op_q == OP_ADD) || (s1_op_q == OP_SUB);
    b_eff          = (s1_op_q == OP_SUB) ? ~s1_b_q : s1_b_q;
    carry_in       = s1_use_c_q ? carry_q : (s1_op_q == OP_SUB);
    sum_full       = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    carry_into_msb = sum_full[WIDTH-1] ^ s1_a_q[WIDTH-1] ^ b_eff[WIDTH-1];

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (s1_op_q)
      OP_NOT_A: alu_res = ~s1_a_q;
      OP_NOT_B: alu_res = ~s1_b_q;
      OP_AND:   alu_res = s1_a_q & s1_b_q;
      OP_OR:    alu_res = s1_a_q | s1_b_q;
      OP_XOR:   alu_res = s1_a_q ^ s1_b_q;
      OP_XNOR:  alu_res = ~(s1_a_q ^ s1_b_q);
      OP_ADD, OP_SUB: begin
        alu_res = sum_full[WIDTH-1:0];
        alu_c   = sum_full[WIDTH];
        alu_v   = carry_into_msb ^ sum_full[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  // Stage 1 next state. A new beat may be loaded in the same cycle the old
  // one leaves for stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_use_c_d = s1_use_c_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a;
      s1_b_d     = b;
      s1_op_d    = op_e'(op);
      s1_use_c_d = use_c;
    end else if (s1_xfer) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state. Result and flags only change on a transfer, so they
  // hold steady while the output is stalled.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    c_d        = c_q;
    n_d        = n_q;
    z_d        = z_q;
    v_d        = v_q;
    if (s1_xfer) begin
      s2_valid_d = 1'b1;
      result_d   = alu_res;
      c_d        = alu_c;
      n_d        = alu_res[WIDTH-1];
      z_d        = (alu_res == '0);
      v_d        = alu_v;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // The carry register updates as an ADD/SUB leaves stage 1, which is exactly
  // when the next beat in issue order becomes visible in stage 1. Chained
  // beats therefore need no bubble.
  always_comb begin
    carry_d = carry_q;
    if (s1_xfer && is_arith) begin
      carry_d = alu_c;
    end
  end

  // Pipeline registers with synchronous reset; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_NOT_A;
      s1_use_c_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      v_q        <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_use_c_q <= s1_use_c_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      c_q        <= c_d;
      n_q        <= n_d;
      z_q        <= z_d;
      v_q        <= v_d;
      carry_q    <= carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign c         = c_q;
  assign n         = n_q;
  assign z         = z_q;
  assign v         = v_q;

`ifdef ALU_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Overflow counter: counts output handshakes that carry v=1, saturates at
  // all-ones, and a clear wins over a same-cycle increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
    end else if (s2_valid_q && out_ready && v_q && !(&ovf_cnt_q)) begin
      ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe at WIDTH=32. A behavioural model computes
// each accepted beat's expected result from plain arithmetic at accept time
// and queues it; every output handshake is compared against the queue head.
// Directed steps cover latency, chained carry, backpressure, reset mid-stream
// and (with ALU_OVF_CNT_EN) the overflow counter; a random phase follows.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 32;

  localparam logic [2:0] OPC_NOT_A = 3'b000;
  localparam logic [2:0] OPC_XOR   = 3'b100;
  localparam logic [2:0] OPC_ADD   = 3'b110;
  localparam logic [2:0] OPC_SUB   = 3'b111;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         use_c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c, n, z, v;
`ifdef ALU_OVF_CNT_EN
  logic         cnt_clr;
  logic [15:0]  ovf_cnt;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         n;
    logic         z;
    logic         v;
  } beat_t;

  beat_t exp_q[$];
  beat_t seen[$];
  logic  model_carry;
  logic  last_acc;
  int    checks;
  int    errors;
  int    accepts;

  alu_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .use_c     (use_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v)
`ifdef ALU_OVF_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .ovf_cnt   (ovf_cnt)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: signed overflow is judged from operand and result signs
  task automatic modelBeat(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2:0] o, input logic uc);
    beat_t        e;
    logic [W-1:0] yy;
    logic         ci;
    logic [63:0]  full;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      3'd0: e.res = ~x;
      3'd1: e.res = ~y;
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~(x ^ y);
      default: begin
        yy    = (o == 3'd7) ? ~y : y;
        ci    = uc ? model_carry : (o == 3'd7);
        full  = 64'(x) + 64'(yy) + 64'(ci);
        e.res = full[W-1:0];
        e.c   = full[W];
        e.v   = (x[W-1] == yy[W-1]) && (e.res[W-1] != x[W-1]);
        model_carry = e.c;
      end
    endcase
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    beat_t g;
    beat_t e;
    g.res = result;
    g.c   = c;
    g.n   = n;
    g.z   = z;
    g.v   = v;
    seen.push_back(g);
    checkVal("out_expected", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkVal("out_result", 64'(g.res), 64'(e.res));
      checkVal("out_flags", 64'({g.c, g.n, g.z, g.v}), 64'({e.c, e.n, e.z, e.v}));
    end
  endtask

  // One clock: observe handshakes at the falling edge, then commit on the
  // rising edge and return 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    last_acc = 1'b0;
    if (reset_n) begin
      if (out_valid && out_ready) checkOutput();
      if (in_valid && in_ready) begin
        modelBeat(a, b, op, use_c);
        accepts++;
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2:0] o, input logic uc);
    in_valid = vld;
    a        = x;
    b        = y;
    op       = o;
    use_c    = uc;
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    checkVal("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int idx;
    int acc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks      = 0;
    errors      = 0;
    accepts     = 0;
    model_carry = 1'b0;
    last_acc    = 1'b0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    op          = OPC_NOT_A;
    use_c       = 1'b0;
    out_ready   = 1'b1;
`ifdef ALU_OVF_CNT_EN
    cnt_clr     = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_result", 64'(result), 64'd0);
    checkVal("rst_flags", 64'({c, n, z, v}), 64'd0);
    checkVal("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    $display("[TB] reset released");

    // Signed overflow ADD and two-cycle latency
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h1, OPC_ADD, 1'b0);
    in_valid = 1'b0;
    checkVal("lat_cycle1_valid", 64'(out_valid), 64'd0);
    tick();
    checkVal("lat_cycle2_valid", 64'(out_valid), 64'd1);
    checkVal("ovf_add_result", 64'(result), 64'h8000_0000);
    checkVal("ovf_add_flags", 64'({c, n, z, v}), 64'b0101);
    drain();

    // SUB to zero followed by XOR
    idx = seen.size();
    applyStimulus(1'b1, 32'h5, 32'h5, OPC_SUB, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_0000, 32'h0000_FFFF, OPC_XOR, 1'b0);
    drain();
    checkVal("sub_zero_result", 64'(seen[idx].res), 64'd0);
    checkVal("sub_zero_flags", 64'({seen[idx].c, seen[idx].n, seen[idx].z, seen[idx].v}), 64'b1010);
    checkVal("xor_result", 64'(seen[idx+1].res), 64'hFFFF_FFFF);
    checkVal("xor_flags", 64'({seen[idx+1].c, seen[idx+1].n, seen[idx+1].z, seen[idx+1].v}), 64'b0100);

    // Back-to-back multi-word chain
    idx = seen.size();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1, OPC_ADD, 1'b0);
    applyStimulus(1'b1, 32'h0, 32'h0, OPC_ADD, 1'b1);
    drain();
    checkVal("chain_lo_result", 64'(seen[idx].res), 64'd0);
    checkVal("chain_lo_c", 64'(seen[idx].c), 64'd1);
    checkVal("chain_hi_result", 64'(seen[idx+1].res), 64'd1);
    checkVal("chain_hi_c", 64'(seen[idx+1].c), 64'd0);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    idx       = seen.size();
    acc0      = accepts;
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd10, 32'd1, OPC_ADD, 1'b0);
    applyStimulus(1'b1, 32'd20, 32'd1, OPC_ADD, 1'b0);
    checkVal("bp_in_ready_low", 64'(in_ready), 64'd0);
    checkVal("bp_two_accepts", 64'(accepts - acc0), 64'd2);
    applyStimulus(1'b1, 32'd30, 32'd1, OPC_ADD, 1'b0);
    applyStimulus(1'b1, 32'd30, 32'd1, OPC_ADD, 1'b0);
    checkVal("bp_no_accept_stalled", 64'(accepts - acc0), 64'd2);
    checkVal("bp_stall_valid", 64'(out_valid), 64'd1);
    checkVal("bp_stall_result", 64'(result), 64'd11);
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'd30, 32'd1, OPC_ADD, 1'b0);
    applyStimulus(1'b1, 32'd40, 32'd1, OPC_ADD, 1'b0);
    drain();
    checkVal("bp_out_count", 64'(seen.size() - idx), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkVal("bp_order", 64'(seen[idx+i].res), 64'(10 * (i + 1) + 1));
    end

`ifdef ALU_OVF_CNT_EN
    // Overflow counter: clear, count three, then clear against an increment
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkVal("ovf_cnt_cleared", 64'(ovf_cnt), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h1, OPC_ADD, 1'b0);
    drain();
    checkVal("ovf_cnt_three", 64'(ovf_cnt), 64'd3);
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'h1, OPC_ADD, 1'b0);
    in_valid = 1'b0;
    tick();
    checkVal("ovf_fourth_valid", 64'(out_valid && v), 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkVal("ovf_cnt_clr_priority", 64'(ovf_cnt), 64'd0);
    drain();
`endif

    // Random traffic with random backpressure and edge-value operands
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'h7FFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'h0;
        default: ;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 3) != 0, ra, rb, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
    end
    drain();

    // Reset with both stages full and the carry register set
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1, OPC_ADD, 1'b0);
    applyStimulus(1'b1, 32'h1, 32'h1, OPC_ADD, 1'b0);
    checkVal("mid_rst_full", 64'(in_ready), 64'd0);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    model_carry = 1'b0;
    checkVal("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("mid_rst_result", 64'(result), 64'd0);
    checkVal("mid_rst_flags", 64'({c, n, z, v}), 64'd0);
    checkVal("mid_rst_in_ready", 64'(in_ready), 64'd1);
    idx       = seen.size();
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0, 32'h0, OPC_ADD, 1'b1);
    drain();
    checkVal("mid_rst_one_output", 64'(seen.size() - idx), 64'd1);
    checkVal("mid_rst_carry_cleared", 64'(seen[seen.size()-1].res), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
